// File: rtl/cle_pkg.sv
// Shared constants, FSM state type and pixel/address helpers for the
// connected-component labeling engine.
package cle_pkg;
    localparam int IMG_DIM  = 32;
    localparam int COORD_W  = 5;
    localparam int ROM_AW   = 7;
    localparam int SRAM_AW  = 10;
    localparam int LBL_W    = 8;
    localparam int MAX_PROV = 64;
    localparam int PROV_W   = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PASS1,
        ST_RESOLVE,
        ST_PASS2,
        ST_DONE
    } cle_state_t;

    function automatic logic [ROM_AW-1:0] rom_addr(input logic [COORD_W-1:0] r,
                                                   input logic [COORD_W-1:0] c);
        return {r, c[COORD_W-1:3]};
    endfunction

    function automatic logic [2:0] bit_idx(input logic [COORD_W-1:0] c);
        return 3'd7 - c[2:0];
    endfunction

    function automatic logic [SRAM_AW-1:0] sram_addr(input logic [COORD_W-1:0] r,
                                                     input logic [COORD_W-1:0] c);
        return {r, c};
    endfunction

    // Minimum of two labels where 0 means "no label".
    function automatic logic [LBL_W-1:0] min_nz(input logic [LBL_W-1:0] a,
                                                input logic [LBL_W-1:0] b);
        if (a == '0) return b;
        if (b == '0) return a;
        return (a < b) ? a : b;
    endfunction
endpackage

// File: rtl/cle_label_table.sv
// Provisional-label equivalence table. Every entry always points directly at
// its root, so find is one lookup and a union rewrites all matching entries.
module cle_label_table
    import cle_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_en,
    output logic [LBL_W-1:0]  alloc_lbl,
    input  logic              union_en,
    input  logic [PROV_W-1:0] lbl_w,
    input  logic [PROV_W-1:0] lbl_nw,
    input  logic [PROV_W-1:0] lbl_n,
    input  logic [PROV_W-1:0] lbl_ne,
    input  logic              resolve_en,
    input  logic [PROV_W-1:0] resolve_idx,
    input  logic [PROV_W-1:0] lookup_idx,
    output logic [LBL_W-1:0]  lookup_final
);
    logic [LBL_W-1:0]  parent    [MAX_PROV];
    logic [LBL_W-1:0]  final_lbl [MAX_PROV];
    logic [PROV_W-1:0] cnt_reg;
    logic [LBL_W-1:0]  next_final_reg;
    logic              sat;
    logic [PROV_W-1:0] new_idx;
    logic [LBL_W-1:0]  root_w, root_nw, root_n, root_ne, min_root;
    logic [LBL_W-1:0]  res_parent, res_val;
    logic              res_is_root;

    assign sat       = (cnt_reg == PROV_W'(MAX_PROV - 1));
    assign new_idx   = sat ? cnt_reg : cnt_reg + PROV_W'(1);
    assign alloc_lbl = LBL_W'(new_idx);

    // Entry 0 is never written, so a zero label resolves to a zero root.
    assign root_w   = parent[lbl_w];
    assign root_nw  = parent[lbl_nw];
    assign root_n   = parent[lbl_n];
    assign root_ne  = parent[lbl_ne];
    assign min_root = min_nz(min_nz(root_w, root_nw), min_nz(root_n, root_ne));

    // Roots are visited in ascending order; a non-root's parent is smaller
    // and has therefore already received its final number.
    assign res_parent   = parent[resolve_idx];
    assign res_is_root  = (res_parent == LBL_W'(resolve_idx));
    assign res_val      = res_is_root ? next_final_reg : final_lbl[res_parent[PROV_W-1:0]];
    assign lookup_final = final_lbl[lookup_idx];

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_reg        <= '0;
            next_final_reg <= LBL_W'(1);
        end else begin
            if (alloc_en) cnt_reg <= new_idx;
            if (resolve_en && res_is_root) next_final_reg <= next_final_reg + LBL_W'(1);
        end
    end

    genvar gi;
    for (gi = 0; gi < MAX_PROV; gi++) begin : g_ent
        logic [LBL_W-1:0] parent_reg;
        logic [LBL_W-1:0] final_reg;
        logic             hit;

        assign hit = (parent_reg != '0) &&
                     ((parent_reg == root_w) || (parent_reg == root_nw) ||
                      (parent_reg == root_n) || (parent_reg == root_ne));

        always_ff @(posedge clk) begin
            if (!reset) begin
                parent_reg <= '0;
                final_reg  <= '0;
            end else begin
                if (alloc_en && !sat && (new_idx == PROV_W'(gi)))
                    parent_reg <= LBL_W'(gi);
                else if (union_en && hit)
                    parent_reg <= min_root;
                if (resolve_en && (resolve_idx == PROV_W'(gi)))
                    final_reg <= res_val;
            end
        end

        assign parent[gi]    = parent_reg;
        assign final_lbl[gi] = final_reg;
    end
endmodule

// File: rtl/component_labeling_engine.sv
// Two-pass 8-connected component labeling of a 32x32 binary image read from
// a packed ROM, writing one label per pixel into an external SRAM.
module component_labeling_engine
    import cle_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         rom_q,
    output logic [ROM_AW-1:0]  rom_a,
    input  logic [7:0]         sram_q,
    output logic [SRAM_AW-1:0] sram_a,
    output logic [LBL_W-1:0]   sram_d,
    output logic               sram_wen,
    output logic               finish
);
    cle_state_t         state_reg;
    logic               wait_reg;
    logic [SRAM_AW-1:0] pix_reg;
    logic [1:0]         ph_reg;
    logic [PROV_W-1:0]  res_idx_reg;
    logic [7:0]         sr_reg;
    logic [LBL_W-1:0]   nw_reg;
    logic [LBL_W-1:0]   lb_row [IMG_DIM];

    logic [COORD_W-1:0] row, col, col_m1, col_p1;
    logic [LBL_W-1:0]   w_lbl, nw_lbl, n_lbl, ne_lbl, min_lbl, pix_lbl;
    logic [LBL_W-1:0]   alloc_lbl, lookup_final;
    logic               obj, in_pass1, alloc_en, union_en, resolve_en;

    assign row    = pix_reg[SRAM_AW-1:COORD_W];
    assign col    = pix_reg[COORD_W-1:0];
    assign col_m1 = col - COORD_W'(1);
    assign col_p1 = col + COORD_W'(1);

    // lb_row holds the current row left of col and the previous row from col
    // onward; nw_reg keeps the previous-row value displaced one pixel ago.
    assign w_lbl   = (col != '0) ? lb_row[col_m1] : '0;
    assign nw_lbl  = (col != '0) ? nw_reg : '0;
    assign n_lbl   = lb_row[col];
    assign ne_lbl  = (col != COORD_W'(IMG_DIM - 1)) ? lb_row[col_p1] : '0;
    assign min_lbl = min_nz(min_nz(w_lbl, nw_lbl), min_nz(n_lbl, ne_lbl));

    assign obj        = sr_reg[7];
    assign in_pass1   = (state_reg == ST_PASS1);
    assign alloc_en   = in_pass1 && obj && (min_lbl == '0);
    assign union_en   = in_pass1 && obj && (min_lbl != '0);
    assign resolve_en = (state_reg == ST_RESOLVE);
    assign pix_lbl    = !obj ? '0 : ((min_lbl != '0) ? min_lbl : alloc_lbl);

    cle_label_table u_table (
        .clk          (clk),
        .reset        (reset),
        .alloc_en     (alloc_en),
        .alloc_lbl    (alloc_lbl),
        .union_en     (union_en),
        .lbl_w        (w_lbl[PROV_W-1:0]),
        .lbl_nw       (nw_lbl[PROV_W-1:0]),
        .lbl_n        (n_lbl[PROV_W-1:0]),
        .lbl_ne       (ne_lbl[PROV_W-1:0]),
        .resolve_en   (resolve_en),
        .resolve_idx  (res_idx_reg),
        .lookup_idx   (sram_q[PROV_W-1:0]),
        .lookup_final (lookup_final)
    );

    genvar gi;
    for (gi = 0; gi < IMG_DIM; gi++) begin : g_lb
        logic [LBL_W-1:0] lb_reg;
        always_ff @(posedge clk) begin
            if (!reset)
                lb_reg <= '0;
            else if (in_pass1 && (col == COORD_W'(gi)))
                lb_reg <= pix_lbl;
        end
        assign lb_row[gi] = lb_reg;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            wait_reg    <= 1'b0;
            pix_reg     <= '0;
            ph_reg      <= '0;
            res_idx_reg <= '0;
            sr_reg      <= '0;
            nw_reg      <= '0;
            rom_a       <= '0;
            sram_a      <= '0;
            sram_d      <= '0;
            sram_wen    <= 1'b1;
            finish      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // One idle cycle lets the ROM return byte 0 after reset.
                    wait_reg <= 1'b1;
                    if (wait_reg) begin
                        sr_reg    <= rom_q;
                        rom_a     <= rom_a + ROM_AW'(1);
                        pix_reg   <= '0;
                        state_reg <= ST_PASS1;
                    end
                end
                ST_PASS1: begin
                    sram_a   <= sram_addr(row, col);
                    sram_d   <= pix_lbl;
                    sram_wen <= 1'b0;
                    nw_reg   <= n_lbl;
                    if (col[2:0] == 3'd7) begin
                        sr_reg <= rom_q;
                        rom_a  <= rom_a + ROM_AW'(1);
                    end else begin
                        sr_reg <= {sr_reg[6:0], 1'b0};
                    end
                    pix_reg <= pix_reg + SRAM_AW'(1);
                    if (pix_reg == '1) begin
                        state_reg   <= ST_RESOLVE;
                        res_idx_reg <= PROV_W'(1);
                    end
                end
                ST_RESOLVE: begin
                    sram_wen    <= 1'b1;
                    res_idx_reg <= res_idx_reg + PROV_W'(1);
                    if (res_idx_reg == '1) begin
                        state_reg <= ST_PASS2;
                        ph_reg    <= '0;
                    end
                end
                ST_PASS2: begin
                    // Address, SRAM read edge, then sample and optionally write.
                    case (ph_reg)
                        2'd0: begin
                            sram_a   <= pix_reg;
                            sram_wen <= 1'b1;
                            ph_reg   <= 2'd1;
                        end
                        2'd1: ph_reg <= 2'd2;
                        2'd2: begin
                            if (sram_q != '0) begin
                                sram_d   <= lookup_final;
                                sram_wen <= 1'b0;
                            end
                            ph_reg  <= 2'd0;
                            pix_reg <= pix_reg + SRAM_AW'(1);
                            if (pix_reg == '1) state_reg <= ST_DONE;
                        end
                        default: ph_reg <= 2'd0;
                    endcase
                end
                ST_DONE: begin
                    sram_wen <= 1'b1;
                    finish   <= 1'b1;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_component_labeling_engine.sv
// Directed bench: behavioural ROM/SRAM models, hand-drawn images with
// hand-computed final label maps.
module tb_component_labeling_engine;
    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rom_q;
    logic [6:0] rom_a;
    logic [7:0] sram_q;
    logic [9:0] sram_a;
    logic [7:0] sram_d;
    logic       sram_wen;
    logic       finish;

    logic [7:0] rom_mem  [128];
    logic [7:0] sram_mem [1024];
    logic [7:0] exp_lbl  [1024];
    logic       fill_req = 1'b0;
    logic       fin_d    = 1'b0;
    int         pass_cnt  = 0;
    int         total_cnt = 0;
    int         rise_cnt  = 0;
    int         late_wr   = 0;
    int         rise_base;

    always #5 clk = ~clk;

    component_labeling_engine dut (
        .clk      (clk),
        .reset    (reset),
        .rom_q    (rom_q),
        .rom_a    (rom_a),
        .sram_q   (sram_q),
        .sram_a   (sram_a),
        .sram_d   (sram_d),
        .sram_wen (sram_wen),
        .finish   (finish)
    );

    always @(posedge clk) rom_q <= rom_mem[rom_a];

    always @(posedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < 1024; i++) sram_mem[i] <= 8'hEE;
        end else if (!sram_wen) begin
            sram_mem[sram_a] <= sram_d;
        end
        if (sram_wen) sram_q <= sram_mem[sram_a];
    end

    always @(posedge clk) begin
        fin_d <= finish;
        if (finish && !fin_d) rise_cnt <= rise_cnt + 1;
        if (finish && !sram_wen) late_wr <= late_wr + 1;
    end

    task automatic check_eq(input string tag, input int obs, input int exp_v);
        total_cnt++;
        if (obs == exp_v) pass_cnt++;
        else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp_v, exp_v);
    endtask

    task automatic clear_img();
        for (int i = 0; i < 128; i++) rom_mem[i] = 8'h00;
        for (int i = 0; i < 1024; i++) exp_lbl[i] = 8'h00;
    endtask

    task automatic set_px(input int r, input int c, input logic [7:0] l);
        logic [7:0] m;
        m = 8'h80;
        m = m >> (c % 8);
        rom_mem[r * 4 + c / 8] = rom_mem[r * 4 + c / 8] | m;
        exp_lbl[r * 32 + c] = l;
    endtask

    task automatic block2(input int r, input int c, input logic [7:0] l);
        set_px(r, c, l);
        set_px(r, c + 1, l);
        set_px(r + 1, c, l);
        set_px(r + 1, c + 1, l);
    endtask

    // Packs {rom_a, sram_a, sram_d, sram_wen, finish}; reset value is 2.
    task automatic check_reset_outs(input string tag);
        check_eq({tag, "_rst_outs"}, int'({rom_a, sram_a, sram_d, sram_wen, finish}), 2);
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        reset    = 1'b0;
        fill_req = 1'b1;
        @(negedge clk);
        fill_req = 1'b0;
        @(negedge clk);
        check_reset_outs(tag);
        reset = 1'b1;
    endtask

    task automatic wait_done(input string tag);
        int cyc;
        cyc = 0;
        while (finish !== 1'b1 && cyc < 9000) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_finish"}, int'(finish), 1);
        check_eq({tag, "_in_budget"}, int'(cyc <= 8192), 1);
    endtask

    task automatic check_image(input string tag);
        int bad;
        int xs;
        bad = 0;
        xs  = 0;
        for (int i = 0; i < 1024; i++) begin
            if ($isunknown(sram_mem[i])) xs++;
            else if (sram_mem[i] != exp_lbl[i]) bad++;
        end
        check_eq({tag, "_wrong_words"}, bad, 0);
        check_eq({tag, "_x_words"}, xs, 0);
    endtask

    task automatic load_blocks();
        clear_img();
        block2(0, 0, 8'd1);
        block2(0, 30, 8'd2);
        block2(15, 15, 8'd3);
        block2(30, 0, 8'd4);
        block2(30, 30, 8'd5);
    endtask

    initial begin
        clear_img();
        apply_reset("zero");
        wait_done("zero");
        check_image("zero");
        check_eq("zero_word1023", int'(sram_mem[1023]), 0);

        clear_img();
        set_px(0, 0, 8'd1);
        apply_reset("single");
        wait_done("single");
        check_image("single");
        check_eq("single_word0", int'(sram_mem[0]), 1);

        clear_img();
        set_px(0, 0, 8'd1);
        set_px(1, 1, 8'd1);
        apply_reset("diag");
        wait_done("diag");
        check_image("diag");
        check_eq("diag_word33", int'(sram_mem[33]), 1);

        // U merges provisional labels 1 and 2; the lone pixel renumbers to 2.
        clear_img();
        for (int r = 0; r < 4; r++) begin
            set_px(r, 0, 8'd1);
            set_px(r, 4, 8'd1);
        end
        for (int c = 1; c < 4; c++) set_px(3, c, 8'd1);
        set_px(10, 10, 8'd2);
        apply_reset("ushape");
        wait_done("ushape");
        check_image("ushape");
        check_eq("ushape_right_top", int'(sram_mem[4]), 1);
        check_eq("ushape_lone", int'(sram_mem[10 * 32 + 10]), 2);

        load_blocks();
        apply_reset("blocks");
        wait_done("blocks");
        check_image("blocks");
        check_eq("blocks_tr", int'(sram_mem[31]), 2);
        check_eq("blocks_br", int'(sram_mem[31 * 32 + 31]), 5);

        // Abort mid-PASS1 with a one-cycle reset, then rerun to completion.
        load_blocks();
        apply_reset("abort_start");
        rise_base = rise_cnt;
        repeat (300) @(negedge clk);
        check_eq("abort_pass1_writing", int'(sram_wen), 0);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outs("abort");
        reset = 1'b1;
        wait_done("abort");
        check_image("abort");
        repeat (20) @(negedge clk);
        check_eq("abort_finish_held", int'(finish), 1);
        check_eq("abort_finish_rises", rise_cnt - rise_base, 1);
        check_eq("writes_after_finish", late_wr, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
